// File: rtl/decoder_3to8_pkg.sv
// Shared widths, types and reset value for the registered 3-to-8 decoder.
package decoder_3to8_pkg;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned OUT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] onehot_t;

    localparam onehot_t DEC_RST_VAL = 8'h00;

    // One-hot pattern for a select value; zero when disabled.
    function automatic onehot_t decode_sel(input logic en, input sel_t sel);
        onehot_t res;
        res = '0;
        if (en) begin
            res[sel] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_3to8_core.sv
// Combinational one-hot decode of a 3-bit select, gated by an enable.
// Ports:
//   en     - decode enable, active-high
//   sel    - select value 0..7
//   dec_c  - one-hot decode (all zero when en=0), combinational
module decoder_3to8_core
    import decoder_3to8_pkg::*;
(
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] dec_c
);

    always_comb begin
        dec_c = decode_sel(en, sel_t'(sel));
    end

endmodule

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 line decoder with active-high enable.
// Ports:
//   clk            - rising-edge clock
//   rst            - synchronous active-high reset, clears all outputs
//   en             - decoder enable, active-high
//   in2, in1, in0  - select bits (in2 is MSB)
//   d7..d0         - registered one-hot outputs, dK high for select K
// Optional build macro:
//   DECODER_3TO8_ONEHOT_CHECK_EN - compiles in a simulation-only checker that
//   flags outputs which are not one-hot after an enabled cycle or not zero
//   after a disabled cycle.
module decoder_3to8
    import decoder_3to8_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in2,
    input  logic in1,
    input  logic in0,
    output logic d7,
    output logic d6,
    output logic d5,
    output logic d4,
    output logic d3,
    output logic d2,
    output logic d1,
    output logic d0
);

    sel_t    sel;
    onehot_t dec_d;
    onehot_t dec_q;

    assign sel = {in2, in1, in0};

    decoder_3to8_core u_core (
        .en    (en),
        .sel   (sel),
        .dec_c (dec_d)
    );

    // Output register; reset wins over enable and select.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= DEC_RST_VAL;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign {d7, d6, d5, d4, d3, d2, d1, d0} = dec_q;

`ifdef DECODER_3TO8_ONEHOT_CHECK_EN
    // Remembers the enable that produced the current dec_q; valid is low
    // right after reset so the reset value is not judged against it.
    logic en_prev_q;
    logic chk_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_prev_q   <= 1'b0;
            chk_valid_q <= 1'b0;
        end else begin
            en_prev_q   <= en;
            chk_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && chk_valid_q) begin
            if (en_prev_q && !$onehot(dec_q)) begin
                $error("decoder_3to8: t=%0t en_prev=1 outputs=%b not one-hot",
                       $time, dec_q);
            end
            if (!en_prev_q && (dec_q != '0)) begin
                $error("decoder_3to8: t=%0t en_prev=0 outputs=%b not zero",
                       $time, dec_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed self-checking bench for decoder_3to8.
module tb_decoder_3to8;

    logic clk;
    logic rst;
    logic en;
    logic in2, in1, in0;
    logic d7, d6, d5, d4, d3, d2, d1, d0;

    int n_cmp;
    int n_err;

    decoder_3to8 dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .in2 (in2),
        .in1 (in1),
        .in0 (in0),
        .d7  (d7),
        .d6  (d6),
        .d5  (d5),
        .d4  (d4),
        .d3  (d3),
        .d2  (d2),
        .d1  (d1),
        .d0  (d0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] obs,
                            input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic r, input logic e, input logic [2:0] s);
        rst = r;
        en  = e;
        {in2, in1, in0} = s;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        n_cmp = 0;
        n_err = 0;
        sweep_exp[0] = 8'b0000_0001;
        sweep_exp[1] = 8'b0000_0010;
        sweep_exp[2] = 8'b0000_0100;
        sweep_exp[3] = 8'b0000_1000;
        sweep_exp[4] = 8'b0001_0000;
        sweep_exp[5] = 8'b0010_0000;
        sweep_exp[6] = 8'b0100_0000;
        sweep_exp[7] = 8'b1000_0000;

        // Reset held two cycles with en=1, sel=5.
        step(1'b1, 1'b1, 3'd5);
        check_eq("reset_c1", outs(), 8'b0000_0000);
        step(1'b1, 1'b1, 3'd5);
        check_eq("reset_c2", outs(), 8'b0000_0000);

        // First edge after release decodes immediately.
        step(1'b0, 1'b1, 3'd5);
        check_eq("release_sel5", outs(), 8'b0010_0000);

        // Enabled sweep.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'(i));
            check_eq($sformatf("en_sweep_%0d", i), outs(), sweep_exp[i]);
        end

        // Disabled sweep.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 3'(i));
            check_eq($sformatf("dis_sweep_%0d", i), outs(), 8'b0000_0000);
        end

        // Enable toggle on sel=3.
        step(1'b0, 1'b1, 3'd3);
        check_eq("toggle_en1a", outs(), 8'b0000_1000);
        step(1'b0, 1'b0, 3'd3);
        check_eq("toggle_en0", outs(), 8'b0000_0000);
        step(1'b0, 1'b1, 3'd3);
        check_eq("toggle_en1b", outs(), 8'b0000_1000);

        // Reset mid-run with sel=7.
        step(1'b0, 1'b1, 3'd7);
        check_eq("mid_pre", outs(), 8'b1000_0000);
        step(1'b1, 1'b1, 3'd7);
        check_eq("mid_rst", outs(), 8'b0000_0000);
        step(1'b0, 1'b1, 3'd7);
        check_eq("mid_post", outs(), 8'b1000_0000);
        step(1'b0, 1'b1, 3'd7);
        check_eq("hold_sel7", outs(), 8'b1000_0000);

        // Simultaneous en and select change.
        step(1'b0, 1'b0, 3'd6);
        check_eq("simul_off", outs(), 8'b0000_0000);
        step(1'b0, 1'b1, 3'd2);
        check_eq("simul_on_sel2", outs(), 8'b0000_0100);
        step(1'b0, 1'b0, 3'd1);
        check_eq("simul_off_sel1", outs(), 8'b0000_0000);
        step(1'b0, 1'b1, 3'd6);
        check_eq("simul_on_sel6", outs(), 8'b0100_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_3to8.md
# decoder_3to8

Registered 3-to-8 line decoder with active-high enable. Decodes the 3-bit select `{in2,in1,in0}` into a one-hot, active-high 8-bit output `d7..d0`, or all-zero when disabled. Used as an address/select decoder in the EE2230 logic blocks. All outputs are registered on one clock with a synchronous active-high reset.

## Interface
- Parameters: none. Widths are fixed: 3 select inputs, 8 outputs.
- `clk` input 1: single clock, rising-edge active.
- `rst` input 1: reset, synchronous and active-high.
- `en` input 1: decoder enable, active-high.
- `in2` input 1: select MSB.
- `in1` input 1: select middle bit.
- `in0` input 1: select LSB.
- `d7`…`d0` output 1 each: decoded lines, active-high. `dK` corresponds to select value K.

## Operation
- Select value `sel = {in2,in1,in0}`, unsigned 0–7.
- Enabled (`en`=1):
  - next `dK` = 1 only for K = `sel`.
  - All other outputs are 0.
  - Exactly one output is high.
- Disabled (`en`=0): next `d7..d0` are all 0, regardless of `sel`.
- Outputs are never active-low and never multi-hot.
- Any X/Z on `en` or select bits is treated as unknown in simulation only. No special recovery logic.
- No internal state beyond the 8 output flops.

## Timing
- Inputs are sampled on the rising edge of `clk`. Outputs update on that same edge.
- Latency is 1 cycle from input change to output.
- Reset (`rst`=1 at a rising edge):
  - Sets all `d7..d0` to 0 on that edge.
  - Reset has priority over `en` and the select inputs.
- First edge with `rst`=0: outputs reflect the inputs sampled at that edge.
- Reset asserted mid-operation: outputs clear at the next edge. Resumed decode needs no warm-up cycle.
- Simultaneous changes of `en` and the select in one cycle: the output reflects the new pair after one edge. There is no glitch at registered outputs.
- Outputs hold their value while the inputs are stable.

## Configuration
- `DECODER_3TO8_ONEHOT_CHECK_EN` defined:
  - Compiles in a simulation checker.
  - Each cycle after reset, outputs must be one-hot when the previous-cycle `en`=1, and all-zero when it was 0.
  - A violation raises `$error` with the time and values.
- Undefined: no checker logic. Functional behaviour is identical.

## Structure
- Package `decoder_3to8_pkg` holds:
  - `SEL_W` = 3 and `OUT_W` = 8.
  - A `sel_t` typedef (logic [2:0]) and an `onehot_t` typedef (logic [7:0]).
  - The reset value constant `DEC_RST_VAL` = 8'h00.
- Sub-module `decoder_3to8_core`:
  - Purely combinational one-hot decode of `sel_t` gated by `en`.
  - The top module registers its output and fans it out to `d7..d0`.

## Test plan
- Reset:
  - Hold `rst`=1 for 2 cycles with `en`=1, sel=5: `d7..d0` = 00000000.
  - Release reset: the next edge gives `d5`=1 only.
- Enabled sweep: `en`=1, sel 0→7, one value per cycle. Each cycle one edge later, `d7..d0` = 00000001, 00000010, … 10000000.
- Disabled sweep: `en`=0, sel 0→7. Every cycle `d7..d0` = 00000000.
- Enable toggle: sel=3, with `en` going 1,0,1 on consecutive cycles. Outputs are 00001000, 00000000, 00001000, each one cycle late.
- Reset mid-run: with `en`=1, sel=7 and `d7`=1, assert `rst` for one cycle. Outputs go 0 at that edge, then `d7`=1 again one edge after release.
- Checker build: define `DECODER_3TO8_ONEHOT_CHECK_EN` and repeat the enabled sweep. No `$error` is reported.
